// File: rtl/tsu_queue_arb.sv
// tsu_queue_arb: round-robin read controller for time-stamp queues with valid/ready output and flush sequencing; define TSU_QUEUE_ARB_STAT_EN for accept/drop counters
module tsu_queue_arb #(
  parameter int N_PORTS = 2,
  parameter int RD_LAT = 1,
  parameter int FLUSH_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  flush,
  input  logic [8*N_PORTS-1:0]  q_rd_stat,
  input  logic [56*N_PORTS-1:0] q_rd_data,
  output logic [N_PORTS-1:0]    q_rd_en,
  output logic                  q_rst,
  output logic                  ts_valid,
  input  logic                  ts_ready,
  output logic [55:0]           ts_data,
  output logic [1:0]            ts_src,
  output logic                  busy
`ifdef TSU_QUEUE_ARB_STAT_EN
  ,
  output logic [16*N_PORTS-1:0] rd_count,
  output logic [15:0]           drop_count
`endif
);
  typedef enum logic [2:0] {ARB, READ, WAIT, HOLD, FLUSH} state_t;
  state_t state, state_nx;
  logic [1:0] last, last_nx, pick;
  logic [3:0] cnt, cnt_nx;
  logic pend, pend_nx, found, cap, drop, stat_unused;
  assign stat_unused = ^q_rd_stat;
  // first port with entries available, searching from one past the last grant
  always_comb begin
    found = 1'b0;
    pick = last;
    for (int k = 1; k <= N_PORTS; k++)
      if (!found && q_rd_stat[8*((int'(last)+k)%N_PORTS) +: 4] != 4'd0) begin
        found = 1'b1;
        pick = 2'((int'(last)+k)%N_PORTS);
      end
  end
  // next state; a flush arriving mid-read is held until the read's capture slot and then discards it
  always_comb begin
    state_nx = state;
    last_nx = last;
    cnt_nx = cnt;
    pend_nx = pend;
    cap = 1'b0;
    drop = 1'b0;
    case (state)
      ARB:
        if (flush) state_nx = FLUSH;
        else if (enable && found) begin
          state_nx = READ;
          last_nx = pick;
        end
      READ: begin
        state_nx = WAIT;
        cnt_nx = 4'd0;
        pend_nx = pend | flush;
      end
      WAIT: begin
        pend_nx = pend | flush;
        if (cnt == 4'(RD_LAT-1)) begin
          state_nx = pend_nx ? FLUSH : HOLD;
          cap = !pend_nx;
          drop = pend_nx;
        end else cnt_nx = cnt + 4'd1;
      end
      HOLD:
        if (flush) begin
          state_nx = FLUSH;
          drop = !ts_ready;
        end else if (ts_ready) state_nx = ARB;
      FLUSH:
        if (flush) cnt_nx = 4'd0;
        else if (cnt == 4'(FLUSH_CYCLES-1)) state_nx = ARB;
        else cnt_nx = cnt + 4'd1;
      default: state_nx = ARB;
    endcase
    if (state_nx == FLUSH && state != FLUSH) begin
      cnt_nx = 4'd0;
      pend_nx = 1'b0;
    end
  end
  // state, grant pointer and outputs registered from the next state so strobes are glitch-free
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= ARB;
      last <= 2'(N_PORTS-1);
      cnt <= 4'd0;
      pend <= 1'b0;
      q_rd_en <= '0;
      q_rst <= 1'b0;
      ts_valid <= 1'b0;
      ts_data <= 56'd0;
      ts_src <= 2'd0;
      busy <= 1'b0;
    end else begin
      state <= state_nx;
      last <= last_nx;
      cnt <= cnt_nx;
      pend <= pend_nx;
      q_rd_en <= state_nx == READ ? N_PORTS'(1) << last_nx : '0;
      q_rst <= state_nx == FLUSH;
      ts_valid <= state_nx == HOLD;
      busy <= state_nx != ARB;
      if (cap) begin
        ts_data <= q_rd_data[56*last +: 56];
        ts_src <= last;
      end
    end
`ifdef TSU_QUEUE_ARB_STAT_EN
  // saturating accept counters cleared on flush entry; drop counter cleared only by reset
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd_count <= '0;
      drop_count <= 16'd0;
    end else begin
      if (state_nx == FLUSH && state != FLUSH) rd_count <= '0;
      else if (state == HOLD && ts_ready && rd_count[16*ts_src +: 16] != 16'hFFFF)
        rd_count[16*ts_src +: 16] <= rd_count[16*ts_src +: 16] + 16'd1;
      if (drop && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
    end
`endif
endmodule

// File: tb/tb_tsu_queue_arb.sv
// tb_tsu_queue_arb: table vectors, directed corner sequences and a randomized run against a queue-level reference model
module tb_tsu_queue_arb;
  localparam int NP = 2, RL = 1, FC = 4;
  logic clk = 1'b0, rst_n = 1'b0, enable = 1'b0, flush = 1'b0, ts_ready = 1'b0;
  logic [8*NP-1:0] q_rd_stat = '0;
  logic [56*NP-1:0] q_rd_data = '0;
  logic [NP-1:0] q_rd_en;
  logic q_rst, ts_valid, busy;
  logic [55:0] ts_data;
  logic [1:0] ts_src;
  int errors = 0, checks = 0;
  logic [55:0] mem [NP][64];
  int hd [NP], tl [NP];
  logic [3:0] junk [NP];
  logic [57:0] expq [$];
  bit mon = 1'b0;
  int mlast = NP-1, since = 100;
  typedef struct {
    int c0, c1;
    logic [3:0] j0, j1;
    logic [55:0] d0, d1;
    logic [1:0] en;
    logic [55:0] dat;
    logic [1:0] src;
  } vec_t;
  vec_t tv [6];

  always #5 clk = ~clk;

  tsu_queue_arb #(.N_PORTS(NP), .RD_LAT(RL), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .flush(flush),
    .q_rd_stat(q_rd_stat), .q_rd_data(q_rd_data), .q_rd_en(q_rd_en), .q_rst(q_rst),
    .ts_valid(ts_valid), .ts_ready(ts_ready), .ts_data(ts_data), .ts_src(ts_src), .busy(busy)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive_stat();
    for (int p = 0; p < NP; p++)
      q_rd_stat[8*p +: 8] = {junk[p], (tl[p]-hd[p] > 15) ? 4'd15 : 4'(tl[p]-hd[p])};
  endtask

  task automatic push(input int p, input logic [55:0] d);
    mem[p][tl[p]] = d;
    tl[p]++;
    drive_stat();
  endtask

  function automatic int qcnt(input int p);
    return tl[p] - hd[p];
  endfunction

  // advance to the next falling edge; emulate the queues and, when monitoring, predict each grant
  task automatic tick();
    int g, e;
    @(negedge clk);
    since++;
    if (q_rd_en != '0) begin
      g = 0;
      for (int p = NP-1; p >= 0; p--) if (q_rd_en[p]) g = p;
      if (mon) begin
        e = -1;
        for (int k = 1; k <= NP; k++) if (e < 0 && qcnt((mlast+k)%NP) > 0) e = (mlast+k)%NP;
        chk("rr_grant", 64'(q_rd_en), e < 0 ? 64'd0 : 64'(1) << e);
        chk("rr_spacing", 64'(since >= RL+2), 64'd1);
        if (e >= 0) begin
          expq.push_back({2'(e), mem[e][hd[e]]});
          mlast = e;
        end
      end
      since = 0;
      if (qcnt(g) > 0) begin
        q_rd_data[56*g +: 56] = mem[g][hd[g]];
        hd[g]++;
      end
    end
    drive_stat();
  endtask

  // the handshake completes at the next rising edge when ts_valid is already high here
  task automatic set_ready(input logic r);
    ts_ready = r;
    if (mon && ts_valid && r) begin
      if (expq.size() != 0) chk("rr_entry", {6'd0, ts_src, ts_data}, {6'd0, expq.pop_front()});
      else chk("rr_entry_extra", {6'd0, ts_src, ts_data}, 64'hFFFF_FFFF_FFFF_FFFF);
    end
  endtask

  task automatic clear_model();
    for (int p = 0; p < NP; p++) begin
      hd[p] = 0;
      tl[p] = 0;
      junk[p] = 4'd0;
    end
    expq.delete();
    q_rd_data = '0;
    mlast = NP-1;
    since = 100;
    drive_stat();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    enable = 1'b0;
    flush = 1'b0;
    ts_ready = 1'b0;
    mon = 1'b0;
    clear_model();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_valid(input string nm);
    int n = 0;
    while (!ts_valid && n < 50) begin
      tick();
      n++;
    end
    if (!ts_valid) begin
      checks++;
      errors++;
      $display("FAIL %s: ts_valid timeout got 0 expected 1", nm);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, gap;
    logic [55:0] hd_data;
    tv[0] = '{1, 0, 4'h0, 4'h0, 56'h00_1234_5678_9ABC, 56'h0, 2'b01, 56'h00_1234_5678_9ABC, 2'd0};
    tv[1] = '{1, 1, 4'h0, 4'h0, 56'h11_1111_2222_3333, 56'h22_4444_5555_6666, 2'b01, 56'h11_1111_2222_3333, 2'd0};
    tv[2] = '{0, 2, 4'h0, 4'h0, 56'h0, 56'h33_4455_6677_8899, 2'b10, 56'h33_4455_6677_8899, 2'd1};
    tv[3] = '{0, 0, 4'hF, 4'hF, 56'h0, 56'h0, 2'b00, 56'h0, 2'd0};
    tv[4] = '{0, 1, 4'h1, 4'h0, 56'h0, 56'hFF_EEDD_CCBB_AA99, 2'b10, 56'hFF_EEDD_CCBB_AA99, 2'd1};
    tv[5] = '{3, 0, 4'h0, 4'h7, 56'h0A_0B0C_0D0E_0F10, 56'h0, 2'b01, 56'h0A_0B0C_0D0E_0F10, 2'd0};
    clear_model();
    @(negedge clk);
    chk("rst_q_rd_en", 64'(q_rd_en), 64'd0);
    chk("rst_q_rst", 64'(q_rst), 64'd0);
    chk("rst_ts_valid", 64'(ts_valid), 64'd0);
    chk("rst_ts_data", 64'(ts_data), 64'd0);
    chk("rst_ts_src", 64'(ts_src), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    for (int i = 0; i < 6; i++) begin
      do_reset();
      for (int k = 0; k < tv[i].c0; k++) push(0, tv[i].d0);
      for (int k = 0; k < tv[i].c1; k++) push(1, tv[i].d1);
      junk[0] = tv[i].j0;
      junk[1] = tv[i].j1;
      drive_stat();
      enable = 1'b1;
      ts_ready = 1'b1;
      tick();
      chk($sformatf("vec%0d_grant", i), 64'(q_rd_en), 64'(tv[i].en));
      if (tv[i].en == 2'b00) begin
        repeat (3) tick();
        chk($sformatf("vec%0d_idle_en", i), 64'(q_rd_en), 64'd0);
        chk($sformatf("vec%0d_idle_busy", i), 64'(busy), 64'd0);
      end else begin
        repeat (RL) begin
          tick();
          chk($sformatf("vec%0d_early_valid", i), 64'(ts_valid), 64'd0);
        end
        tick();
        chk($sformatf("vec%0d_valid", i), 64'(ts_valid), 64'd1);
        chk($sformatf("vec%0d_data", i), 64'(ts_data), 64'(tv[i].dat));
        chk($sformatf("vec%0d_src", i), 64'(ts_src), 64'(tv[i].src));
      end
    end
    do_reset();
    for (int k = 0; k < 3; k++) begin
      push(0, 56'hA0 + 56'(k));
      push(1, 56'hB0 + 56'(k));
    end
    enable = 1'b1;
    ts_ready = 1'b1;
    n = 0;
    gap = 0;
    for (int c = 0; c < 200 && n < 6; c++) begin
      tick();
      if (q_rd_en != '0) begin
        chk($sformatf("rr_order%0d", n), 64'(q_rd_en), (n % 2) ? 64'd2 : 64'd1);
        if (n > 0) chk("rr_gap", 64'(gap + 1 >= RL + 2), 64'd1);
        n++;
        gap = 0;
      end else gap++;
    end
    chk("rr_count", 64'(n), 64'd6);
    do_reset();
    push(0, 56'hC0FFEE);
    push(1, 56'hBEEF);
    enable = 1'b1;
    wait_valid("bp_first");
    chk("bp_src", 64'(ts_src), 64'd0);
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("bp_valid", 64'(ts_valid), 64'd1);
      chk("bp_data", 64'(ts_data), 64'h00C0FFEE);
      chk("bp_src_hold", 64'(ts_src), 64'd0);
      chk("bp_no_rd", 64'(q_rd_en), 64'd0);
    end
    ts_ready = 1'b1;
    tick();
    chk("bp_done_valid", 64'(ts_valid), 64'd0);
    chk("bp_arb_no_rd", 64'(q_rd_en), 64'd0);
    chk("bp_arb_busy", 64'(busy), 64'd0);
    tick();
    chk("bp_next_grant", 64'(q_rd_en), 64'd2);
    do_reset();
    push(0, 56'h1111);
    push(1, 56'h2222);
    enable = 1'b1;
    ts_ready = 1'b1;
    tick();
    chk("fl_read", 64'(q_rd_en), 64'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl_wait_rst", 64'(q_rst), 64'd0);
    chk("fl_wait_valid", 64'(ts_valid), 64'd0);
    for (int c = 0; c < FC; c++) begin
      tick();
      chk("fl_q_rst", 64'(q_rst), 64'd1);
      chk("fl_valid", 64'(ts_valid), 64'd0);
      chk("fl_no_rd", 64'(q_rd_en), 64'd0);
      chk("fl_busy", 64'(busy), 64'd1);
    end
    tick();
    chk("fl_end_rst", 64'(q_rst), 64'd0);
    chk("fl_after_no_rd", 64'(q_rd_en), 64'd0);
    chk("fl_after_valid", 64'(ts_valid), 64'd0);
    tick();
    chk("fl_ptr_kept", 64'(q_rd_en), 64'd2);
    ts_ready = 1'b0;
    wait_valid("fl_hold");
    chk("fl_hold_src", 64'(ts_src), 64'd1);
    chk("fl_hold_data", 64'(ts_data), 64'h2222);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl_hold_drop", 64'(ts_valid), 64'd0);
    chk("fl_hold_rst", 64'(q_rst), 64'd1);
    do_reset();
    for (int k = 0; k < 5; k++) push(1, 56'h5500 + 56'(k));
    ts_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      chk("en_off_rd", 64'(q_rd_en), 64'd0);
      chk("en_off_busy", 64'(busy), 64'd0);
    end
    enable = 1'b1;
    tick();
    chk("en_on_grant", 64'(q_rd_en), 64'd2);
    do_reset();
    push(0, 56'h7777);
    push(1, 56'h8888);
    enable = 1'b1;
    wait_valid("ar_hold");
    chk("ar_src", 64'(ts_src), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", 64'(ts_valid), 64'd0);
    chk("ar_rd_en", 64'(q_rd_en), 64'd0);
    chk("ar_q_rst", 64'(q_rst), 64'd0);
    chk("ar_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    clear_model();
    push(0, 56'h9999);
    push(1, 56'hAAAA);
    ts_ready = 1'b1;
    tick();
    chk("ar_port0_first", 64'(q_rd_en), 64'd1);
    do_reset();
    for (int p = 0; p < NP; p++) begin
      junk[p] = 4'($urandom_range(0, 15));
      n = $urandom_range(0, 6);
      for (int k = 0; k < n; k++) begin
        hd_data = {24'($urandom), 32'($urandom)};
        push(p, hd_data);
      end
    end
    mon = 1'b1;
    for (int c = 0; c < 400; c++) begin
      tick();
      enable = $urandom_range(0, 3) != 0;
      set_ready(1'($urandom_range(0, 1)));
    end
    enable = 1'b1;
    n = 0;
    while ((qcnt(0) + qcnt(1) != 0 || expq.size() != 0 || ts_valid) && n < 500) begin
      tick();
      set_ready(1'b1);
      n++;
    end
    chk("rand_drained_q", 64'(qcnt(0) + qcnt(1)), 64'd0);
    chk("rand_drained_out", 64'(expq.size()), 64'd0);
    mon = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
